serial_readout_tx: RTL and testbench
====================================

Name: serial_readout_tx

Overview:
- Serial transmitter that accepts a parallel word over a valid/ready handshake.
- Shifts the word out on a generated serial clock (sclk) with a serial data line (sdo) and an active-low frame select (cs_n).
- Forms the transmit end of the team's sclk/sdi serial load interface, so a controller can stream load values into counter blocks.
- Runs entirely in the system clock domain; sclk is a registered, divided output.

Parameters:
- WIDTH, 8, bits per frame (>=1).
- DIV, 2, system clock cycles per sclk half-period (>=1).
- MSB_FIRST, 1, 1 = tx_data[WIDTH-1] sent first; 0 = tx_data[0] sent first.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  WIDTH  word to transmit; sampled only on handshake.
- tx_valid  input  1  word offered.
- tx_ready  output  1  block idle and able to accept.
- sclk  output  1  serial clock; receiver samples sdo on sclk rising edge.
- sdo  output  1  serial data.
- cs_n  output  1  frame select, low for the whole frame.
- busy  output  1  frame in progress (= ~tx_ready).
- done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (rst=1 at a clk edge) drives: sclk=0, sdo=0, cs_n=1, tx_ready=1, busy=0, done=0; shift register, bit counter and divider counter all 0; state IDLE.
- All outputs are registered, with no combinational path from inputs to outputs.
- States: IDLE, LOW, HIGH.
- IDLE:
  - tx_ready=1, cs_n=1, sclk=0.
  - At an edge with tx_valid=1, latch tx_data into the shift register, go to LOW, set cs_n=0, drive the first bit on sdo, clear the bit and divider counters.
- LOW:
  - sclk=0, sdo holds the current bit.
  - After DIV cycles, go to HIGH and set sclk=1.
- HIGH:
  - sclk=1, sdo held stable.
  - After DIV cycles, sclk=0.
  - If the bit counter = WIDTH-1: go to IDLE, set cs_n=1, sdo=0, done=1 for that one cycle, tx_ready=1.
  - Otherwise: increment the bit counter, drive the next bit on sdo, go to LOW.
- sdo changes only on edges where sclk falls (or the frame starts), giving DIV cycles of setup and DIV cycles of hold around each sclk rise.
- Frame timing, with the accepting edge at t0:
  - sclk rises at edges t0+DIV+2*DIV*k, for k = 0..WIDTH-1.
  - cs_n is low for exactly 2*DIV*WIDTH cycles.
  - done is high in the cycle following edge t0+2*DIV*WIDTH.
- Bit order follows MSB_FIRST. The shift direction is fixed at elaboration.
- tx_valid while busy is ignored (tx_ready=0, no latch). tx_data changes mid-frame do not affect the frame.
- Back-to-back frames:
  - In the done cycle tx_ready=1, so a word offered then is accepted at the next edge.
  - cs_n is high for exactly one cycle between frames. This is the minimum inter-frame gap.
- Reset mid-frame:
  - The frame aborts and all outputs take their reset values at that edge.
  - done is not pulsed and no partial frame resumes.
- The divider counter is sized for DIV. DIV=1 gives sclk = clk/2.

Test Plan:
- Reset: hold rst 2 cycles with tx_valid=1 -> sclk=0, sdo=0, cs_n=1, tx_ready=1, busy=0, done=0; no frame starts while rst=1.
- WIDTH=8, DIV=2, MSB_FIRST=1, send 0xA5 at t0 -> cs_n low 32 cycles; 8 sclk rises at t0+2, t0+6, ..., t0+30; sdo sampled at rises = 1,0,1,0,0,1,0,1; done high one cycle after edge t0+32; tx_ready low throughout.
- MSB_FIRST=0, DIV=1, send 0x01 -> frame 16 cycles; sclk rises at t0+1, t0+3, ..., t0+15; sampled bits = 1,0,0,0,0,0,0,0.
- Back-to-back: tx_valid held high, 0x3C then 0xC3 -> second word accepted in the done cycle; cs_n high exactly 1 cycle between frames; both frames bit-exact.
- Busy rejection: during the 0x5A frame, pulse tx_valid with 0xFF and change tx_data -> frame still carries 0x5A; 0xFF never sent; single done.
- Reset after 3rd sclk rise -> next edge cs_n=1, sclk=0, no done; a following send of 0x81 completes normally, bit-exact.

Source files
------------

// File: rtl/serial_readout_tx.sv
// Serial word transmitter: parallel word in over valid/ready, shifted out on a
// divided sclk with sdo and an active-low frame select. All outputs registered.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no frame; tx_ready=1, cs_n=1, sclk=0; accepts tx_data on tx_valid
// LOW   | sclk low half-period; sdo holds the current bit (setup time)
// HIGH  | sclk high half-period; sdo held stable (hold time)
module serial_readout_tx #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             sclk,
    output logic             sdo,
    output logic             cs_n,
    output logic             busy,
    output logic             done
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shift_reg, shift_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
    logic             sclk_nxt, sdo_nxt, cs_n_nxt, ready_nxt, done_nxt;
    logic [WIDTH-1:0] shift_adv;

    // Bit that goes on the wire first from a given shift-register image.
    function automatic logic lead_bit(input logic [WIDTH-1:0] v);
        if (MSB_FIRST != 0)
            return v[WIDTH-1];
        else
            return v[0];
    endfunction

    // Shift direction fixed at elaboration; the next bit always sits at the lead position.
    assign shift_adv = (MSB_FIRST != 0) ? (shift_reg << 1) : (shift_reg >> 1);

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            sclk      <= 1'b0;
            sdo       <= 1'b0;
            cs_n      <= 1'b1;
            tx_ready  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            div_cnt   <= div_cnt_nxt;
            sclk      <= sclk_nxt;
            sdo       <= sdo_nxt;
            cs_n      <= cs_n_nxt;
            tx_ready  <= ready_nxt;
            busy      <= ~ready_nxt;
            done      <= done_nxt;
        end
    end

    // Next-state and next-output decode; sdo only moves on sclk fall or frame start.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_reg;
        bit_cnt_nxt = bit_cnt;
        div_cnt_nxt = div_cnt;
        sclk_nxt    = sclk;
        sdo_nxt     = sdo;
        cs_n_nxt    = cs_n;
        ready_nxt   = tx_ready;
        done_nxt    = 1'b0;

        case (state)
            IDLE: begin
                sclk_nxt  = 1'b0;
                cs_n_nxt  = 1'b1;
                ready_nxt = 1'b1;
                if (tx_valid) begin
                    shift_nxt   = tx_data;
                    sdo_nxt     = lead_bit(tx_data);
                    cs_n_nxt    = 1'b0;
                    ready_nxt   = 1'b0;
                    bit_cnt_nxt = '0;
                    div_cnt_nxt = '0;
                    state_nxt   = LOW;
                end
            end

            LOW: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_nxt = '0;
                    sclk_nxt    = 1'b1;
                    state_nxt   = HIGH;
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end

            HIGH: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_nxt = '0;
                    sclk_nxt    = 1'b0;
                    if (bit_cnt == BIT_LAST) begin
                        cs_n_nxt  = 1'b1;
                        sdo_nxt   = 1'b0;
                        done_nxt  = 1'b1;
                        ready_nxt = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        shift_nxt   = shift_adv;
                        sdo_nxt     = lead_bit(shift_adv);
                        state_nxt   = LOW;
                    end
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_readout_tx.sv
// Directed bench: two instances (8b/DIV=2/MSB-first and 8b/DIV=1/LSB-first),
// a bit-level receiver that samples sdo on observed sclk rises, and hand-derived frame timing.
module tb_serial_readout_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] dat [2];
    logic       vld [2];

    logic ready0, sclk0, sdo0, cs_n0, busy0, done0;
    logic ready1, sclk1, sdo1, cs_n1, busy1, done1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_readout_tx #(.WIDTH(8), .DIV(2), .MSB_FIRST(1)) dut0 (
        .clk(clk), .rst(rst), .tx_data(dat[0]), .tx_valid(vld[0]),
        .tx_ready(ready0), .sclk(sclk0), .sdo(sdo0), .cs_n(cs_n0),
        .busy(busy0), .done(done0)
    );

    serial_readout_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(0)) dut1 (
        .clk(clk), .rst(rst), .tx_data(dat[1]), .tx_valid(vld[1]),
        .tx_ready(ready1), .sclk(sclk1), .sdo(sdo1), .cs_n(cs_n1),
        .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observes one frame starting right after the accepting edge, ending in the done cycle.
    task automatic frame(input int sel, input int div, input bit msb,
                         input logic [7:0] exp_word, input int inject_at, input string tag);
        int         len;
        int         n_rise, bad_time, cs_low, dones, ready_hi;
        logic [7:0] w;
        logic       prev, s, d, c, dn, rd;
        len      = 2 * div * 8;
        n_rise   = 0;
        bad_time = 0;
        dones    = 0;
        ready_hi = 0;
        w        = 8'h00;
        prev     = sel ? sclk1 : sclk0;
        cs_low   = ((sel ? cs_n1 : cs_n0) == 1'b0) ? 1 : 0;
        if ((sel ? ready1 : ready0) == 1'b1) ready_hi++;
        for (int n = 1; n <= len; n++) begin
            if (inject_at > 0 && n == inject_at) begin
                vld[sel] = 1'b1;
                dat[sel] = 8'hFF;
            end else if (inject_at > 0 && n == inject_at + 1) begin
                vld[sel] = 1'b0;
                dat[sel] = 8'h00;
            end
            step();
            s  = sel ? sclk1  : sclk0;
            d  = sel ? sdo1   : sdo0;
            c  = sel ? cs_n1  : cs_n0;
            dn = sel ? done1  : done0;
            rd = sel ? ready1 : ready0;
            if (s && !prev) begin
                if (n != div + 2 * div * n_rise) bad_time++;
                w = msb ? {w[6:0], d} : {d, w[7:1]};
                n_rise++;
            end
            prev = s;
            if (n < len) begin
                if (!c) cs_low++;
                if (dn) dones++;
                if (rd) ready_hi++;
            end else begin
                chk({tag, " end cs_n"}, 32'(c), 32'd1);
                chk({tag, " end done"}, 32'(dn), 32'd1);
                chk({tag, " end ready"}, 32'(rd), 32'd1);
                chk({tag, " end sclk"}, 32'(s), 32'd0);
            end
        end
        chk({tag, " rises"}, 32'(n_rise), 32'd8);
        chk({tag, " rise timing errs"}, 32'(bad_time), 32'd0);
        chk({tag, " word"}, 32'(w), 32'(exp_word));
        chk({tag, " cs_n low cycles"}, 32'(cs_low), 32'(len));
        chk({tag, " early done"}, 32'(dones), 32'd0);
        chk({tag, " ready during frame"}, 32'(ready_hi), 32'd0);
    endtask

    // Runs idle cycles on instance sel and checks that no frame or done appears.
    task automatic quiet(input int sel, input int cycles, input string tag);
        int lows, dones;
        lows  = 0;
        dones = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if ((sel ? cs_n1 : cs_n0) == 1'b0) lows++;
            if ((sel ? done1 : done0) == 1'b1) dones++;
        end
        chk({tag, " cs_n low"}, 32'(lows), 32'd0);
        chk({tag, " done"}, 32'(dones), 32'd0);
    endtask

    initial begin
        dat[0] = 8'hA5;
        dat[1] = 8'h01;
        vld[0] = 1'b1;
        vld[1] = 1'b1;
        rst    = 1'b1;

        // Reset held with tx_valid asserted.
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst sclk", 32'(sclk0), 32'd0);
            chk("rst sdo", 32'(sdo0), 32'd0);
            chk("rst cs_n", 32'(cs_n0), 32'd1);
            chk("rst ready", 32'(ready0), 32'd1);
            chk("rst busy", 32'(busy0), 32'd0);
            chk("rst done", 32'(done0), 32'd0);
            chk("rst cs_n dut1", 32'(cs_n1), 32'd1);
        end
        vld[0] = 1'b0;
        vld[1] = 1'b0;
        rst    = 1'b0;
        quiet(0, 3, "post rst");

        // 0xA5, MSB first, DIV=2.
        dat[0] = 8'hA5;
        vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        chk("a5 busy", 32'(busy0), 32'd1);
        chk("a5 first sdo", 32'(sdo0), 32'd1);
        frame(0, 2, 1'b1, 8'hA5, 0, "a5");
        quiet(0, 4, "a5 after");

        // 0x01, LSB first, DIV=1.
        dat[1] = 8'h01;
        vld[1] = 1'b1;
        step();
        vld[1] = 1'b0;
        frame(1, 1, 1'b0, 8'h01, 0, "lsb01");
        quiet(1, 4, "lsb01 after");

        // Back-to-back with tx_valid held high.
        dat[0] = 8'h3C;
        vld[0] = 1'b1;
        step();
        dat[0] = 8'hC3;
        frame(0, 2, 1'b1, 8'h3C, 0, "b2b 1st");
        step();
        vld[0] = 1'b0;
        chk("b2b gap cs_n", 32'(cs_n0), 32'd0);
        chk("b2b 2nd done clr", 32'(done0), 32'd0);
        frame(0, 2, 1'b1, 8'hC3, 0, "b2b 2nd");
        quiet(0, 4, "b2b after");

        // Busy rejection: 0xFF offered mid-frame.
        dat[0] = 8'h5A;
        vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        frame(0, 2, 1'b1, 8'h5A, 9, "busy rej");
        quiet(0, 20, "busy rej after");

        // Reset after the third sclk rise (edge t0+10 for DIV=2).
        dat[0] = 8'hE7;
        vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("pre-abort sclk", 32'(sclk0), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort cs_n", 32'(cs_n0), 32'd1);
        chk("abort sclk", 32'(sclk0), 32'd0);
        chk("abort sdo", 32'(sdo0), 32'd0);
        chk("abort done", 32'(done0), 32'd0);
        chk("abort ready", 32'(ready0), 32'd1);
        quiet(0, 40, "abort after");

        dat[0] = 8'h81;
        vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        frame(0, 2, 1'b1, 8'h81, 0, "post abort 81");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
